// File: rtl/hs32_wb_master.sv
// rtl/hs32_wb_master.sv - Wishbone B4 classic initiator with bus-timeout watchdog
module hs32_wb_master #(
  parameter int TIMEOUT_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stb,
  input  logic        i_rw,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_dtw,
  input  logic [3:0]  i_sel,
  output logic        o_ack,
  output logic        o_err,
  output logic [31:0] o_dtr,
  output logic        o_busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [TIMEOUT_BITS-1:0] WD_ONE = TIMEOUT_BITS'(1);
  localparam logic [TIMEOUT_BITS-1:0] WD_MAX = {TIMEOUT_BITS{1'b1}};

  logic [0:0]              state;
  logic [TIMEOUT_BITS-1:0] wd;
  logic [TIMEOUT_BITS-1:0] wd_next;
  logic                    wd_expired;

  // wd holds (wait cycle number - 1), so wd_next is the 1-based count of the
  // current WAIT cycle; expiry fires in the cycle whose count is all ones.
  assign wd_next    = wd + WD_ONE;
  assign wd_expired = (wd_next == WD_MAX);

  // Cycle, strobe and busy come straight from the state register so that an
  // asynchronous reset drops them without waiting for a clock edge.
  assign wbm_cyc_o = (state == S_WAIT);
  assign wbm_stb_o = (state == S_WAIT);
  assign o_busy    = (state == S_WAIT);

  // Request capture, completion (err > ack > timeout) and watchdog counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wd        <= '0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'h0;
      wbm_dat_o <= 32'h0;
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_dtr     <= 32'h0;
    end else begin
      o_ack <= 1'b0;
      o_err <= 1'b0;
      if (state == S_IDLE) begin
        if (i_stb) begin
          wbm_we_o  <= i_rw;
          wbm_sel_o <= i_sel;
          wbm_adr_o <= i_addr;
          wbm_dat_o <= i_dtw;
          wd        <= '0;
          state     <= S_WAIT;
        end
      end else begin
        if (wbm_err_i) begin
          o_ack <= 1'b1;
          o_err <= 1'b1;
          o_dtr <= 32'h0;
          state <= S_IDLE;
        end else if (wbm_ack_i) begin
          o_ack <= 1'b1;
          o_dtr <= wbm_we_o ? 32'h0 : wbm_dat_i;
          state <= S_IDLE;
        end else if (wd_expired) begin
          o_ack <= 1'b1;
          o_err <= 1'b1;
          o_dtr <= 32'h0;
          state <= S_IDLE;
        end else begin
          wd <= wd_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_hs32_wb_master.sv
// tb/tb_hs32_wb_master.sv - self-checking bench for hs32_wb_master
module tb_hs32_wb_master;

  localparam int TB_TO   = 4;
  localparam int TO_CYC  = (1 << TB_TO) - 1;
  localparam int K_ACK   = 0;
  localparam int K_ERR   = 1;
  localparam int K_BOTH  = 2;
  localparam int K_NONE  = 3;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] dtw;
    logic [3:0]  sel;
    int          ws;
    int          kind;
    logic [31:0] rdata;
    logic        extra;
    logic        exp_err;
    logic [31:0] exp_dtr;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] dtr;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        i_stb;
  logic        i_rw;
  logic [31:0] i_addr;
  logic [31:0] i_dtw;
  logic [3:0]  i_sel;
  logic        o_ack;
  logic        o_err;
  logic [31:0] o_dtr;
  logic        o_busy;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc_cnt = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];

  hs32_wb_master #(.TIMEOUT_BITS(TB_TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_stb     (i_stb),
    .i_rw      (i_rw),
    .i_addr    (i_addr),
    .i_dtw     (i_dtw),
    .i_sel     (i_sel),
    .o_ack     (o_ack),
    .o_err     (o_err),
    .o_dtr     (o_dtr),
    .o_busy    (o_busy),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Completion monitor: every o_ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_ack) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ack: got o_ack=1 at cycle %0d expected no completion", cyc_cnt);
      end else begin
        mon_e = sb.pop_front();
        check("ack_cycle", cyc_cnt, mon_e.cyc);
        check("o_err", o_err, mon_e.err);
        check("o_dtr", o_dtr, mon_e.dtr);
      end
    end else if (o_err) begin
      n_total++;
      $display("FAIL err_without_ack: got o_err=1 expected 0 at cycle %0d", cyc_cnt);
    end
  end

  // Called just after a rising edge; leaves the bench in the o_ack cycle.
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n;
    i_stb  = 1'b1;
    i_rw   = v.rw;
    i_addr = v.addr;
    i_dtw  = v.dtw;
    i_sel  = v.sel;
    e.err  = v.exp_err;
    e.dtr  = v.exp_dtr;
    e.cyc  = cyc_cnt + v.exp_lat;
    sb.push_back(e);
    n = (v.kind == K_NONE) ? TO_CYC : v.ws + 1;
    @(posedge clk); #1;
    i_stb  = 1'b0;
    i_rw   = ~v.rw;
    i_addr = ~v.addr;
    i_dtw  = ~v.dtw;
    i_sel  = ~v.sel;
    for (int j = 0; j < n; j++) begin
      check("bus_hold",
            {wbm_cyc_o, wbm_stb_o, o_busy, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
            {1'b1, 1'b1, 1'b1, v.rw, v.sel, v.addr, v.dtw});
      if (v.extra && j == 1 && j < n - 1) begin
        i_stb  = 1'b1;
        i_addr = 32'hBAD0_0000;
      end
      if (j == v.ws && v.kind != K_NONE) begin
        wbm_ack_i = (v.kind == K_ACK) || (v.kind == K_BOTH);
        wbm_err_i = (v.kind == K_ERR) || (v.kind == K_BOTH);
        wbm_dat_i = v.rdata;
      end
      @(posedge clk); #1;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = $urandom;
      i_stb     = 1'b0;
    end
    check("cyc_drop", {wbm_cyc_o, wbm_stb_o, o_busy}, 3'b000);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end of test expected completion");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    vecs[0] = '{1'b0, 32'h3000_0010, 32'h0000_0000, 4'hF, 0,  K_ACK,  32'hDEAD_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF, 2};
    vecs[1] = '{1'b1, 32'h3000_0020, 32'h1234_5678, 4'h3, 3,  K_ACK,  32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 5};
    vecs[2] = '{1'b0, 32'h3000_0100, 32'h0000_0000, 4'hF, 1,  K_BOTH, 32'hAAAA_5555, 1'b0, 1'b1, 32'h0000_0000, 3};
    vecs[3] = '{1'b0, 32'h3000_0104, 32'h0000_0000, 4'h0, 2,  K_ACK,  32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D, 4};
    vecs[4] = '{1'b0, 32'h3000_0200, 32'h0000_0000, 4'hF, 0,  K_NONE, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_0000, 16};
    vecs[5] = '{1'b0, 32'h3000_0204, 32'h0000_0000, 4'hC, 14, K_ACK,  32'hCAFE_0001, 1'b0, 1'b0, 32'hCAFE_0001, 16};
    vecs[6] = '{1'b1, 32'h3000_0300, 32'h5555_AAAA, 4'hF, 0,  K_ERR,  32'h7777_7777, 1'b0, 1'b1, 32'h0000_0000, 2};
    vecs[7] = '{1'b1, 32'h3000_0304, 32'h0F0F_0F0F, 4'h1, 3,  K_ACK,  32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 5};
    vecs[8] = '{1'b0, 32'h3000_0308, 32'h0000_0000, 4'hF, 13, K_ACK,  32'h1357_9BDF, 1'b0, 1'b0, 32'h1357_9BDF, 15};

    rst       = 1'b1;
    i_stb     = 1'b0;
    i_rw      = 1'b0;
    i_addr    = 32'h0;
    i_dtw     = 32'h0;
    i_sel     = 4'h0;
    wbm_dat_i = 32'h0;
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {o_ack, o_err, o_dtr, o_busy, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
          {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
    rst = 1'b0;
    @(posedge clk); #1;

    // Responder ack/err while idle must not start or complete anything.
    wbm_ack_i = 1'b1;
    wbm_err_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("idle_ignore_resp", {wbm_cyc_o, o_busy, o_ack}, 3'b000);
    end
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: each vector issues its request in the previous o_ack cycle.
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Idle afterwards: no stray bus cycle, read data held.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("idle_hold", {wbm_cyc_o, o_ack, o_dtr}, {1'b0, 1'b0, 32'h1357_9BDF});
    end

    // Asynchronous reset in the middle of a WAIT cycle.
    i_stb  = 1'b1;
    i_rw   = 1'b0;
    i_addr = 32'h3000_0400;
    i_sel  = 4'hF;
    @(posedge clk); #1;
    i_stb = 1'b0;
    check("pre_reset_cyc", {wbm_cyc_o, o_busy}, 2'b11);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_reset_drop", {wbm_cyc_o, wbm_stb_o, o_busy}, 3'b000);
    @(posedge clk); #1;
    check("reset_outputs_mid",
          {o_ack, o_err, o_dtr, o_busy, wbm_cyc_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o},
          {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
    rst = 1'b0;
    @(posedge clk); #1;

    rv = '{1'b0, 32'h3000_0500, 32'h0000_0000, 4'hF, 1, K_ACK, 32'h600D_600D, 1'b0, 1'b0, 32'h600D_600D, 3};
    run_vec(rv);
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
